gshare_pht: RTL and testbench

Pattern history table for the gshare branch predictor. It sits directly downstream of the global history register in the branch-prediction unit and consumes its history output. In the fetch stage it XORs the history with the fetch PC to index a table of 2-bit saturating counters. It returns a registered taken/not-taken prediction plus the index used. The decode stage later returns that index with the resolved outcome to train the addressed counter.

---
 rtl/gshare_pht.sv | 114 +++++++++++
 tb/tb_gshare_pht.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_pht.sv
// -----------------------------------------------------------------------------
// gshare_pht
//
// Pattern history table for a gshare branch predictor. The fetch PC is hashed
// with the global history to select a 2-bit saturating counter. The MSB of that
// counter is returned as a registered taken/not-taken prediction, together with
// the index that was used. Decode later returns that index with the resolved
// outcome so the same counter can be trained.
//
// Ports
//   clk           clock, all state updates on posedge
//   rst           asynchronous active-low reset
//   lookup_en     fetch presents a PC to predict
//   lookup_pc     fetch PC (bits [1:0] ignored)
//   ghr_in        current global history
//   stall         fetch stall, holds the prediction outputs
//   pred_valid    registered prediction is valid
//   pred_taken    predicted direction (counter MSB)
//   pred_index    table index used, carried down the pipe for training
//   update_en     decode resolves a conditional branch
//   update_index  index returned from pred_index of that branch
//   update_taken  resolved direction
// -----------------------------------------------------------------------------
module gshare_pht #(
   parameter int GHR_WIDTH  = 5,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lookup_en,
   input  logic [ADDR_WIDTH-1:0] lookup_pc,
   input  logic [GHR_WIDTH-1:0]  ghr_in,
   input  logic                  stall,
   output logic                  pred_valid,
   output logic                  pred_taken,
   output logic [GHR_WIDTH-1:0]  pred_index,
   input  logic                  update_en,
   input  logic [GHR_WIDTH-1:0]  update_index,
   input  logic                  update_taken
);

   localparam int DEPTH = 2 ** GHR_WIDTH;

   // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   logic [1:0]           table_q [DEPTH];
   logic [GHR_WIDTH-1:0] lookup_index;
   logic [1:0]           update_next;
   logic [1:0]           lookup_next;

   // Only the word-aligned PC bits just above the byte offset feed the hash;
   // the rest are deliberately dropped.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc[ADDR_WIDTH-1:GHR_WIDTH+2], lookup_pc[1:0]};

   // Saturating step: never wraps between 11 and 00.
   function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == CTR_STRONG_T) ? ctr : ctr + 2'd1;
      end
      return (ctr == CTR_STRONG_NT) ? ctr : ctr - 2'd1;
   endfunction

   assign lookup_index = lookup_pc[GHR_WIDTH+1:2] ^ ghr_in;
   assign update_next  = sat_step(table_q[update_index], update_taken);

   // Write-to-read bypass so a lookup of the counter being trained this cycle
   // sees the trained value.
   always_comb begin
      // NOTE: assign a default first so every path drives the output and no
      // latch is inferred.
      lookup_next = table_q[lookup_index];
      if (update_en && (update_index == lookup_index)) begin
         lookup_next = update_next;
      end
   end

   // Counter table. Training continues during stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: this table is built from flops, not a RAM macro, so every
         // entry can be forced to weak-NT by the asynchronous reset.
         for (int i = 0; i < DEPTH; i++) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops update together at the edge.
            table_q[i] <= CTR_WEAK_NT;
         end
      end else if (update_en) begin
         table_q[update_index] <= update_next;
      end
   end

   // Prediction register: stall holds everything, otherwise a lookup loads a
   // fresh prediction and an idle cycle only drops valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_index <= '0;
      end else if (!stall) begin
         if (lookup_en) begin
            pred_valid <= 1'b1;
            pred_index <= lookup_index;
            pred_taken <= lookup_next[1];
         end else begin
            pred_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gshare_pht.sv
// -----------------------------------------------------------------------------
// tb_gshare_pht
//
// Directed bench for gshare_pht. Each cycle the expected prediction outputs are
// derived from a behavioural model of the counter table, pushed to a queue,
// then popped and compared one cycle later. Key points are also checked
// against literal values.
// -----------------------------------------------------------------------------
module tb_gshare_pht;

   localparam int GW = 5;
   localparam int AW = 32;

   typedef struct packed {
      logic          valid;
      logic          taken;
      logic [GW-1:0] index;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          lookup_en;
   logic [AW-1:0] lookup_pc;
   logic [GW-1:0] ghr_in;
   logic          stall;
   logic          pred_valid;
   logic          pred_taken;
   logic [GW-1:0] pred_index;
   logic          update_en;
   logic [GW-1:0] update_index;
   logic          update_taken;

   gshare_pht #(.GHR_WIDTH(GW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .lookup_en    (lookup_en),
      .lookup_pc    (lookup_pc),
      .ghr_in       (ghr_in),
      .stall        (stall),
      .pred_valid   (pred_valid),
      .pred_taken   (pred_taken),
      .pred_index   (pred_index),
      .update_en    (update_en),
      .update_index (update_index),
      .update_taken (update_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   // Model state
   logic [1:0]    m_ctr [2**GW];
   logic          m_valid;
   logic          m_taken;
   logic [GW-1:0] m_index;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] model_step(input logic [1:0] c, input logic t);
      if (t)  return (c == 2'b11) ? 2'b11 : c + 2'd1;
      return (c == 2'b00) ? 2'b00 : c - 2'd1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2**GW; i++) m_ctr[i] = 2'b01;
      m_valid = 1'b0;
      m_taken = 1'b0;
      m_index = '0;
      sb.delete();
   endtask

   // One clock cycle: drive inputs, predict, wait for the edge, compare.
   task automatic cycle(input logic le, input logic [AW-1:0] pc, input logic [GW-1:0] ghr,
                        input logic st, input logic ue, input logic [GW-1:0] ui,
                        input logic ut);
      exp_t          e;
      logic [GW-1:0] idx;
      logic [1:0]    nu;
      logic [1:0]    ln;
      lookup_en    = le;
      lookup_pc    = pc;
      ghr_in       = ghr;
      stall        = st;
      update_en    = ue;
      update_index = ui;
      update_taken = ut;
      idx = pc[GW+1:2] ^ ghr;
      nu  = model_step(m_ctr[ui], ut);
      ln  = (ue && ui == idx) ? nu : m_ctr[idx];
      if (!st) begin
         if (le) begin
            m_valid = 1'b1;
            m_index = idx;
            m_taken = ln[1];
         end else begin
            m_valid = 1'b0;
         end
      end
      if (ue) m_ctr[ui] = nu;
      e.valid = m_valid;
      e.taken = m_taken;
      e.index = m_index;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check("sb_valid", 32'(pred_valid), 32'(e.valid));
         check("sb_taken", 32'(pred_taken), 32'(e.taken));
         check("sb_index", 32'(pred_index), 32'(e.index));
      end
   endtask

   task automatic lk(input logic [GW-1:0] idx);
      cycle(1'b1, {25'd0, idx, 2'b00}, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic upd(input logic [GW-1:0] idx, input logic t);
      cycle(1'b0, '0, '0, 1'b0, 1'b1, idx, t);
   endtask

   task automatic idle_inputs();
      lookup_en    = 1'b0;
      lookup_pc    = '0;
      ghr_in       = '0;
      stall        = 1'b0;
      update_en    = 1'b0;
      update_index = '0;
      update_taken = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      model_reset();
      rst = 1'b0;

      // Reset state, with no clock edge yet
      #3;
      check("rst_valid", 32'(pred_valid), 32'd0);
      check("rst_taken", 32'(pred_taken), 32'd0);
      check("rst_index", 32'(pred_index), 32'd0);
      #9 rst = 1'b1; // released between edges (t=12)

      // Every counter starts weak-NT
      for (int i = 0; i < 2**GW; i++) begin
         lk(GW'(i));
         check("rst_ctr_weak_nt", 32'(pred_taken), 32'd0);
      end

      // Index hash
      cycle(1'b1, 32'h0000_0010, 5'b00001, 1'b0, 1'b0, '0, 1'b0);
      check("hash_valid", 32'(pred_valid), 32'd1);
      check("hash_idx5", 32'(pred_index), 32'd5);
      cycle(1'b1, 32'hFFFF_FF90, 5'b00000, 1'b0, 1'b0, '0, 1'b0);
      check("hash_idx4", 32'(pred_index), 32'd4);

      // Training and saturation on index 5
      for (int k = 0; k < 3; k++) begin
         upd(5'd5, 1'b1);
         lk(5'd5);
         check("train_taken", 32'(pred_taken), 32'd1);
      end
      upd(5'd5, 1'b0);
      lk(5'd5);
      check("train_nt1_weak_t", 32'(pred_taken), 32'd1);
      upd(5'd5, 1'b0);
      lk(5'd5);
      check("train_nt2_weak_nt", 32'(pred_taken), 32'd0);
      upd(5'd5, 1'b0);
      upd(5'd5, 1'b0);
      upd(5'd5, 1'b1); // 00 -> 01 if saturation held at 00
      lk(5'd5);
      check("sat_low_hold", 32'(pred_taken), 32'd0);

      // Same-cycle bypass on index 7
      cycle(1'b1, {25'd0, 5'd7, 2'b00}, '0, 1'b0, 1'b1, 5'd7, 1'b1);
      check("bypass_taken", 32'(pred_taken), 32'd1);
      cycle(1'b1, {25'd0, 5'd8, 2'b00}, '0, 1'b0, 1'b1, 5'd7, 1'b1);
      check("bypass_other_idx", 32'(pred_taken), 32'd0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      check("idle_valid_low", 32'(pred_valid), 32'd0);

      // Stall holds outputs while training index 3 continues
      lk(5'd3);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, {25'd0, 5'd10, 2'b00}, '0, 1'b1, 1'b1, 5'd3, 1'b1);
         check("stall_valid", 32'(pred_valid), 32'd1);
         check("stall_index", 32'(pred_index), 32'd3);
         check("stall_taken", 32'(pred_taken), 32'd0);
      end
      lk(5'd10);
      check("post_stall_index", 32'(pred_index), 32'd10);
      lk(5'd3);
      check("post_stall_trained", 32'(pred_taken), 32'd1);

      // Mid-operation reset
      upd(5'd9, 1'b1);
      upd(5'd9, 1'b1);
      lk(5'd9);
      check("pre_reset_taken", 32'(pred_taken), 32'd1);
      idle_inputs();
      #2 rst = 1'b0;
      #1;
      check("midrst_valid", 32'(pred_valid), 32'd0);
      check("midrst_taken", 32'(pred_taken), 32'd0);
      check("midrst_index", 32'(pred_index), 32'd0);
      #1 rst = 1'b1;
      model_reset();
      lk(5'd9);
      check("post_reset_ctr9", 32'(pred_taken), 32'd0);
      check("post_reset_idx9", 32'(pred_index), 32'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
